// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and slices the
// returned word into opcode/one/two/three fields for the IF/ID buffer.
module if_fetch_stage #(
  parameter int                  PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}},
  parameter logic [3:0]          HALT_OPCODE = 4'hF,
  parameter int                  CNT_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hazard,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  output logic [3:0]          opcode,
  output logic [3:0]          one,
  output logic [3:0]          two,
  output logic [3:0]          three,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                halted,
  output logic [15:0]         fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  issue_s;

  // State register: PC, run/halt state and issued-instruction counter
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  // Next-state logic; priority is reset, branch, halted, hazard, halt opcode, normal fetch
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    issue_s = 1'b0;
    if (reset) begin
      pc_d    = RESET_PC;
      state_d = ST_RUN;
    end else if (branch_taken) begin
      // The instruction on the bus this cycle is squashed and never counted
      pc_d    = branch_target;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_HALTED: begin
          pc_d    = pc_q;
          state_d = ST_HALTED;
        end
        ST_RUN: begin
          if (hazard) begin
            pc_d = pc_q;
          end else if (imem_data[15:12] == HALT_OPCODE) begin
            state_d = ST_HALTED;
            issue_s = 1'b1;
          end else begin
            pc_d    = pc_q + PC_ONE;
            issue_s = 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Saturating issue counter
  always_comb begin
    cnt_d = cnt_q;
    if (reset) begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end else if (issue_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode: fields become a NOP whenever the word on the bus is not being issued
  always_comb begin
    imem_addr   = pc_q;
    pc_o        = pc_q;
    halted      = 1'b0;
    opcode      = 4'h0;
    one         = 4'h0;
    two         = 4'h0;
    three       = 4'h0;
    fetch_count = 16'h0000;
    fetch_count[CNT_WIDTH-1:0] = cnt_q;
    if (reset) begin
      halted = 1'b0;
    end else if (state_q == ST_HALTED) begin
      halted = 1'b1;
    end else if (!branch_taken) begin
      opcode = imem_data[15:12];
      one    = imem_data[11:8];
      two    = imem_data[7:4];
      three  = imem_data[3:0];
    end else begin
      halted = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed scoreboard bench: the driver queues hand-computed per-cycle expectations and a
// negedge monitor pops and compares them. A 4-bit-counter instance exercises saturation.
module tb_if_fetch_stage;

  typedef struct {
    string       name;
    logic [7:0]  pc;
    logic [15:0] fields;
    logic        halted;
    logic [15:0] cnt;
    logic [15:0] sat_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, hazard, branch_taken;
  logic [7:0]  branch_target, imem_addr, pc_o;
  logic [15:0] imem_data, fetch_count;
  logic [3:0]  opcode, one, two, three;
  logic        halted;

  logic [7:0]  s_addr, s_pc;
  logic [3:0]  s_op, s_one, s_two, s_three;
  logic        s_halted;
  logic [15:0] s_cnt;

  logic [15:0] mem [256];
  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          sat_m = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  if_fetch_stage #(.PC_WIDTH(8), .RESET_PC(8'h00), .HALT_OPCODE(4'hF)) u_dut (
    .clk(clk), .reset(reset), .hazard(hazard), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .opcode(opcode), .one(one), .two(two), .three(three), .pc_o(pc_o),
    .halted(halted), .fetch_count(fetch_count)
  );

  if_fetch_stage #(.PC_WIDTH(8), .RESET_PC(8'h00), .HALT_OPCODE(4'hF), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(reset), .hazard(1'b0), .branch_taken(1'b0),
    .branch_target(8'h00), .imem_addr(s_addr), .imem_data(16'h1111),
    .opcode(s_op), .one(s_one), .two(s_two), .three(s_three), .pc_o(s_pc),
    .halted(s_halted), .fetch_count(s_cnt)
  );

  // Monitor: compare outputs against the oldest queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if ({pc_o, opcode, one, two, three, halted, fetch_count, s_cnt} !==
          {e.pc, e.fields, e.halted, e.cnt, e.sat_cnt}) begin
        miscompares++;
        $display("FAIL %s: got pc=%h fields=%h halted=%b cnt=%h sat=%h, want pc=%h fields=%h halted=%b cnt=%h sat=%h",
                 e.name, pc_o, {opcode, one, two, three}, halted, fetch_count, s_cnt,
                 e.pc, e.fields, e.halted, e.cnt, e.sat_cnt);
      end
    end
  end

  // Apply one cycle of inputs, queue its expectation, then advance past the clock edge
  task automatic cyc(input string nm, input logic rst, input logic hz, input logic br,
                     input logic [7:0] tgt, input logic [7:0] pc, input logic [15:0] f,
                     input logic h, input logic [15:0] cnt);
    exp_t e;
    reset = rst; hazard = hz; branch_taken = br; branch_target = tgt;
    e.name = nm; e.pc = pc; e.fields = f; e.halted = h; e.cnt = cnt;
    e.sat_cnt = 16'(sat_m);
    exp_q.push_back(e);
    if (rst) sat_m = 0;
    else if (sat_m != 15) sat_m++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 | 16'(i);
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h2345;
    mem[8'h09] = 16'hF000;
    mem[8'h40] = 16'hABCD;
    mem[8'hFF] = 16'h7EEF;

    reset = 1'b1; hazard = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    @(posedge clk);
    #1;
    cyc("reset",      1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 16'd0);
    cyc("run_pc0",    1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h1234, 1'b0, 16'd0);
    cyc("run_pc1",    1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 16'h2345, 1'b0, 16'd1);
    cyc("run_pc2",    1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 16'h5A02, 1'b0, 16'd2);
    cyc("run_pc3",    1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 16'h5A03, 1'b0, 16'd3);
    cyc("run_pc4",    1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 16'h5A04, 1'b0, 16'd4);
    for (int i = 0; i < 3; i++)
      cyc("stall_pc5",  1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 16'h5A05, 1'b0, 16'd5);
    cyc("unstall",    1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 16'h5A05, 1'b0, 16'd5);
    cyc("run_pc6",    1'b0, 1'b0, 1'b0, 8'h00, 8'h06, 16'h5A06, 1'b0, 16'd6);
    cyc("br_flush",   1'b0, 1'b0, 1'b1, 8'h40, 8'h07, 16'h0000, 1'b0, 16'd7);
    cyc("br_hazard",  1'b0, 1'b1, 1'b1, 8'h40, 8'h40, 16'h0000, 1'b0, 16'd7);
    cyc("at_target",  1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 16'hABCD, 1'b0, 16'd7);
    cyc("br_to_8",    1'b0, 1'b0, 1'b1, 8'h08, 8'h41, 16'h0000, 1'b0, 16'd8);
    cyc("run_pc8",    1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 16'h5A08, 1'b0, 16'd8);
    cyc("halt_haz",   1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 16'hF000, 1'b0, 16'd9);
    cyc("halt_issue", 1'b0, 1'b0, 1'b0, 8'h00, 8'h09, 16'hF000, 1'b0, 16'd9);
    for (int i = 0; i < 10; i++)
      cyc("halted",   1'b0, 1'(i % 2), 1'b0, 8'h00, 8'h09, 16'h0000, 1'b1, 16'd10);
    cyc("halt_exit",  1'b0, 1'b0, 1'b1, 8'h00, 8'h09, 16'h0000, 1'b1, 16'd10);
    cyc("resume_pc0", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h1234, 1'b0, 16'd10);
    cyc("br_to_ff",   1'b0, 1'b0, 1'b1, 8'hFF, 8'h01, 16'h0000, 1'b0, 16'd11);
    cyc("run_pcff",   1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 16'h7EEF, 1'b0, 16'd11);
    cyc("wrap_pc0",   1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h1234, 1'b0, 16'd12);
    cyc("br_to_9",    1'b0, 1'b0, 1'b1, 8'h09, 8'h01, 16'h0000, 1'b0, 16'd13);
    cyc("halt2",      1'b0, 1'b0, 1'b0, 8'h00, 8'h09, 16'hF000, 1'b0, 16'd13);
    cyc("rst_halted", 1'b1, 1'b1, 1'b0, 8'h00, 8'h09, 16'h0000, 1'b0, 16'd14);
    cyc("rst_held",   1'b1, 1'b1, 1'b1, 8'h33, 8'h00, 16'h0000, 1'b0, 16'd0);
    cyc("post_rst",   1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h1234, 1'b0, 16'd0);
    cyc("post_rst1",  1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 16'h2345, 1'b0, 16'd1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends with a summary
  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline buffer.
- Owns the program counter (PC) and drives the instruction-memory address. It slices the returned 16-bit instruction into opcode/one/two/three fields for the IF/ID buffer.
- Handles stall (hazard), taken-branch redirect with flush, and a halt state entered on the HALT opcode.

Parameters:
- PC_WIDTH, 8, width of PC and instruction-memory address
- RESET_PC, 0, PC value loaded on reset
- HALT_OPCODE, 4'hF, opcode value that halts fetch

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- hazard  input  1  stall request from hazard logic; same signal drives the IF/ID buffer hold
- branch_taken  input  1  redirect request from a later stage
- branch_target  input  PC_WIDTH  redirect destination, sampled when branch_taken=1
- imem_addr  output  PC_WIDTH  instruction-memory address, equal to current PC
- imem_data  input  16  instruction word; combinational read of imem_addr in the same cycle
- opcode  output  4  instruction field [15:12] to IF/ID buffer
- one  output  4  instruction field [11:8]
- two  output  4  instruction field [7:4]
- three  output  4  instruction field [3:0]
- pc_o  output  PC_WIDTH  PC of the instruction currently presented
- halted  output  1  high while in HALTED state
- fetch_count  output  16  number of instructions issued since reset, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset, and is sampled only on the rising edge of clk.
- State machine: RUN and HALTED. The PC register, state and fetch_count are the only state.
- Reset values (next edge with reset=1): PC=RESET_PC, state=RUN, fetch_count=0.
- Outputs while reset=1: opcode/one/two/three forced to 0 (NOP), halted=0.
- Addressing: imem_addr = pc_o = PC at all times (combinational).
- Field outputs:
  - RUN with branch_taken=0: field outputs = imem_data slices, zero latency.
  - Otherwise (HALTED, or branch_taken=1): fields = 0 (NOP).
- Next-state priority at each rising edge, highest first:
  1. reset: as above.
  2. branch_taken=1, any state: PC <= branch_target; state <= RUN; the squashed instruction is not counted. Branch overrides hazard.
  3. HALTED: PC holds; state stays HALTED.
  4. hazard=1 (RUN): PC holds; same instruction re-presented next cycle; not counted.
  5. RUN, imem_data[15:12]==HALT_OPCODE: HALT is issued once (counted); PC holds; state <= HALTED.
  6. RUN, normal: PC <= PC+1, wrapping from all-ones to 0 with no flag; fetch_count increments.
- fetch_count saturates at 16'hFFFF; no wrap.
- Hazard on a HALT instruction: no transition; HALT is re-presented until hazard drops.
- Halt exit: only via branch_taken or reset. Resumed fetch presents the target instruction on the cycle after the redirect edge.
- Reset mid-operation (any state, any hazard/branch value): reset wins on that edge.
- All outputs are combinational functions of registered state plus imem_data/branch_taken. There are no combinational loops through hazard.

Test Plan:
- Reset then run: reset=1 for 2 cycles, memory holds 16'h1234 at 0 and 16'h2345 at 1, hazard=0 -> cycle 1 after reset: pc_o=0, opcode=1, one=2, two=3, three=4. Next cycle: pc_o=1, opcode=2. fetch_count=2 after two edges.
- Stall: assert hazard for 3 cycles at pc_o=5 -> pc_o stays 5, fields unchanged, fetch_count unchanged. Release hazard -> pc_o=6 next cycle.
- Branch flush: branch_taken=1, branch_target=8'h40 at pc_o=7 -> that cycle's fields=0. Next cycle pc_o=8'h40. fetch_count not incremented for pc 7. Branch with hazard=1 simultaneously -> still redirects to 8'h40.
- Halt: memory holds 16'hF000 at pc 9 -> opcode=F presented once. Then halted=1, pc_o stays 9, fields=0 for 10 cycles. branch_taken with target 0 -> halted=0, pc_o=0 next cycle.
- Wrap and saturation: PC_WIDTH=8, start at 8'hFF, no stall -> next pc_o=0. Force fetch_count to 16'hFFFF via long run (or a reduced-width variant) -> stays 16'hFFFF.
- Reset mid-operation: assert reset while HALTED with hazard=1 -> next edge pc_o=RESET_PC, halted=0, fetch_count=0, fields=0 while reset is held.
